// File: rtl/fifo_instruction_decoder.sv
// fifo_instruction_decoder
// Read-side consumer of the dual instruction FIFO pair. Pops one dataA/dataB
// pair at a time, decodes the opcode in dataA[3:0], and issues a single-cycle
// write strobe to the register bank, sprite memory, background memory or
// polygon memory. Back-pressure from the targets holds the pending write.
//
// Optional build macro: DECODER_STATS_EN adds saturating exec/illegal counters.
//
// Ports:
//   clk, reset          decoder clock (FIFO read clock), synchronous active-high reset
//   rdempty             OR of both FIFO empty flags
//   dataA, dataB        FIFO outputs (normal mode: valid the cycle after rdreq)
//   stall               target back-pressure
//   rdreq               read request to both FIFOs
//   reg_wr/addr/data    register-bank write
//   spr_wr/addr         sprite memory write (data on mem_data)
//   bg_wr/addr          background memory write (data on mem_data)
//   mem_data            RGB 3:3:3 pixel data shared by sprite/background writes
//   poly_wr/addr/data   polygon descriptor write
//   busy                high whenever the decoder is not idle
//   exec_count          (DECODER_STATS_EN) strobes issued, saturating
//   illegal_count       (DECODER_STATS_EN) illegal opcodes discarded, saturating
module fifo_instruction_decoder #(
   parameter int REG_ADDR_W    = 5,
   parameter int SPRITE_ADDR_W = 14,
   parameter int BG_ADDR_W     = 12,
   parameter int POLY_ADDR_W   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rdempty,
   input  logic [31:0]              dataA,
   input  logic [31:0]              dataB,
   input  logic                     stall,
   output logic                     rdreq,
   output logic                     reg_wr,
   output logic [REG_ADDR_W-1:0]    reg_addr,
   output logic [31:0]              reg_data,
   output logic                     spr_wr,
   output logic [SPRITE_ADDR_W-1:0] spr_addr,
   output logic                     bg_wr,
   output logic [BG_ADDR_W-1:0]     bg_addr,
   output logic [8:0]               mem_data,
   output logic                     poly_wr,
   output logic [POLY_ADDR_W-1:0]   poly_addr,
   output logic [31:0]              poly_data,
`ifdef DECODER_STATS_EN
   output logic [15:0]              exec_count,
   output logic [15:0]              illegal_count,
`endif
   output logic                     busy
);

   // Only the opcode plus the widest address field of dataA is ever used,
   // so only that many bits are latched.
   localparam int MAX_AB = (SPRITE_ADDR_W > BG_ADDR_W) ? SPRITE_ADDR_W : BG_ADDR_W;
   localparam int MAX_RP = (REG_ADDR_W > POLY_ADDR_W) ? REG_ADDR_W : POLY_ADDR_W;
   localparam int A_W    = 4 + ((MAX_AB > MAX_RP) ? MAX_AB : MAX_RP);

   localparam logic [3:0] OP_WBR = 4'h0;
   localparam logic [3:0] OP_WSM = 4'h1;
   localparam logic [3:0] OP_WBM = 4'h2;
   localparam logic [3:0] OP_DP  = 4'h3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_EXEC
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [A_W-1:0]   latch_a;
   logic [31:0]      latch_b;
   logic [3:0]       opcode;
   logic             exec_fire;
   logic             unused_data_a;

   assign unused_data_a = ^dataA[31:A_W];
   assign opcode        = latch_a[3:0];

   // State register plus the instruction latch. The FIFO is not show-ahead,
   // so the popped word is only on dataA/dataB during WAIT; it is captured at
   // the WAIT->EXEC edge and the outputs hold it until the next capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         latch_a <= '0;
         latch_b <= '0;
      end else begin
         state <= state_next;
         if (state == ST_WAIT) begin
            latch_a <= dataA[A_W-1:0];
            latch_b <= dataB;
         end
      end
   end

   // Next-state and strobe decode. A strobe fires only on the EXEC cycle
   // with stall low; an illegal opcode still spends that cycle and is dropped.
   always_comb begin
      state_next = state;
      rdreq      = 1'b0;
      exec_fire  = 1'b0;
      reg_wr     = 1'b0;
      spr_wr     = 1'b0;
      bg_wr      = 1'b0;
      poly_wr    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rdempty && !stall) state_next = ST_READ;
         end
         ST_READ: begin
            rdreq      = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            if (!stall) begin
               exec_fire  = 1'b1;
               state_next = ST_IDLE;
               case (opcode)
                  OP_WBR:  reg_wr  = 1'b1;
                  OP_WSM:  spr_wr  = 1'b1;
                  OP_WBM:  bg_wr   = 1'b1;
                  OP_DP:   poly_wr = 1'b1;
                  default: ;
               endcase
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign busy      = (state != ST_IDLE);
   assign reg_addr  = latch_a[4 +: REG_ADDR_W];
   assign reg_data  = latch_b;
   assign spr_addr  = latch_a[4 +: SPRITE_ADDR_W];
   assign bg_addr   = latch_a[4 +: BG_ADDR_W];
   assign mem_data  = latch_b[8:0];
   assign poly_addr = latch_a[4 +: POLY_ADDR_W];
   assign poly_data = latch_b;

`ifdef DECODER_STATS_EN
   // Saturating counters: legal opcodes count as issued strobes, the rest
   // as illegal. Opcodes 0..3 are exactly those with the top two bits clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         exec_count    <= '0;
         illegal_count <= '0;
      end else if (exec_fire) begin
         if (opcode[3:2] == 2'b00) begin
            if (exec_count != 16'hFFFF) exec_count <= exec_count + 16'd1;
         end else begin
            if (illegal_count != 16'hFFFF) illegal_count <= illegal_count + 16'd1;
         end
      end
   end
`else
   logic unused_exec_fire;
   assign unused_exec_fire = exec_fire;
`endif

endmodule
